pos_pkt_dispatcher: RTL

POS_PKT_DISPATCHER -- requirements
Module: pos_pkt_dispatcher

---
 rtl/MD_pkg.sv | 28 ++
 rtl/pos_dispatch_fifo.sv | 63 ++++++
 rtl/pos_pkt_dispatcher.sv | 94 +++++++++
 3 files changed

// File: rtl/MD_pkg.sv
// MD_pkg -- shared constants and types for the MD position-packet datapath.
//
// Contents:
//   POS_PKT_STRUCT_WIDTH   width of one position packet on the ring
//   DISPATCH_FIFO_DEPTH    default buffer depth of the PE dispatcher
//   DISPATCH_BP_THRESHOLD  default occupancy at which the dispatcher throttles the ring
//   pos_pkt_t              field view of a position packet
//   ptr_width()            pointer width helper that stays legal for a count of one
package MD_pkg;

  localparam int POS_PKT_STRUCT_WIDTH  = 64;
  localparam int DISPATCH_FIFO_DEPTH   = 16;
  localparam int DISPATCH_BP_THRESHOLD = 12;

  typedef struct packed {
    logic [7:0]  particle_id;
    logic [7:0]  cell_id;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] pos_z;
  } pos_pkt_t;

  // $clog2(1) is 0, which would give a zero-width vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pos_dispatch_fifo.sv
// pos_dispatch_fifo -- synchronous first-word-fall-through FIFO with count.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset (pointers and count only)
//   push        write wr_data this cycle (caller guarantees space or a same-cycle pop)
//   wr_data     packet to store
//   pop         retire the head this cycle (caller guarantees non-empty)
//   rd_data     current head, valid whenever count is non-zero
//   count       registered occupancy
//   count_next  occupancy after this cycle's push/pop
module pos_dispatch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; stale contents are never presented because the
  // count gates validity downstream.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free;
  // full vs. empty is told apart by the count, not by pointer equality.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/pos_pkt_dispatcher.sv
// pos_pkt_dispatcher -- buffers position packets from the ring and hands them
// out round-robin to the force-PE lanes.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   i_pos_pkt        packet from the input ring node
//   i_pos_pkt_valid  i_pos_pkt valid this cycle (no ready; throttled by o_back_pressure)
//   o_back_pressure  registered throttle back to the ring node
//   o_pe_pkt         head packet, broadcast to every PE
//   o_pe_valid       one-hot valid naming the PE that owns the head
//   i_pe_ready       per-PE ready; only the targeted PE's bit matters
//   o_occupancy      registered FIFO count
//   o_overflow       sticky: a packet arrived at a full FIFO and was dropped
module pos_pkt_dispatcher
  import MD_pkg::*;
#(
  parameter int FIFO_DEPTH   = DISPATCH_FIFO_DEPTH,
  parameter int BP_THRESHOLD = DISPATCH_BP_THRESHOLD,
  parameter int NUM_PE       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0] i_pos_pkt,
  input  logic                            i_pos_pkt_valid,
  output logic                            o_back_pressure,
  output logic [POS_PKT_STRUCT_WIDTH-1:0] o_pe_pkt,
  output logic [NUM_PE-1:0]               o_pe_valid,
  input  logic [NUM_PE-1:0]               i_pe_ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_occupancy,
  output logic                            o_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RR_W  = ptr_width(NUM_PE);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [RR_W-1:0]  rr_ptr;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // A transfer needs the targeted PE ready; other ready bits are ignored so
  // the head never skips a busy lane. A same-cycle pop frees a slot, which
  // lets a push into a full FIFO still be accepted.
  assign pop  = !rst && !empty && i_pe_ready[rr_ptr];
  assign push = !rst && i_pos_pkt_valid && (!full || pop);

  pos_dispatch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (POS_PKT_STRUCT_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wr_data    (i_pos_pkt),
    .pop        (pop),
    .rd_data    (o_pe_pkt),
    .count      (count),
    .count_next (count_next)
  );

  assign o_occupancy = count;

  // Valid is forced low during reset so no transfer can be seen while the
  // buffer is being discarded.
  always_comb begin
    o_pe_valid = '0;
    if (!rst && !empty) o_pe_valid[rr_ptr] = 1'b1;
  end

  // Back-pressure looks at next-cycle occupancy so the ring sees the throttle
  // one cycle earlier, leaving FIFO_DEPTH-BP_THRESHOLD slots for packets
  // already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      o_back_pressure <= 1'b0;
      o_overflow      <= 1'b0;
    end else begin
      if (pop) begin
        rr_ptr <= (rr_ptr == RR_W'(NUM_PE - 1)) ? '0 : rr_ptr + 1'b1;
      end
      o_back_pressure <= (count_next >= CNT_W'(BP_THRESHOLD));
      if (i_pos_pkt_valid && !push) o_overflow <= 1'b1;
    end
  end

endmodule
